player1: RTL and testbench
==========================

# player1

Player-1 code recorder for SpyMangler. It turns presses on the player-1 key into a Morse-style bit stream: a dot is `10`, a dash is `1110`. It packs the symbols into a 20-bit value and holds that value stable, with a valid flag, for the `player2` stage. `player2` consumes `value` as its `player1_value` input and compares player 2's entry against it.

## Interface
Parameters:
- `WIDTH`, default 20: bit width of the code register. Must be even and ≥ 4.
- `DASH_MIN`, default 2: a press of at least this many clock cycles is a dash; a shorter press is a dot.

Ports:
- `clock`, input, 1: single clock, typically the `rate_divider` tick.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `user_input`, input, 1: symbol key, active-low.
- `next_input`, input, 1: clear/undo key, active-low.
- `done_input`, input, 1: finish key, active-low.
- `value`, output, `WIDTH`: recorded code, right-aligned, newest symbol in the LSBs.
- `length`, output, 5: number of valid bits in `value`.
- `valid`, output, 1: code is final; `value` is stable while high.
- `overflow`, output, 1: sticky; a symbol was dropped because it did not fit.
- `q`, output, 18: LED mirror, `value[17:0]`.

## Operation
- All three keys pass through a 2-flop synchronizer. A press is a falling edge of the synchronized signal and a release is a rising edge.
- There are three states: RECORD, PRESS and DONE.
- Reset value is RECORD for the state. `value`, `length`, `valid` and `overflow` all reset to 0.
- RECORD:
  - A `user_input` press moves to PRESS with the hold counter at 1. This takes priority.
  - Otherwise, a `done_input` press with `length`>0 moves to DONE. With `length`==0 it is ignored.
  - Otherwise, a `next_input` press behaves as defined under Configuration.
- PRESS:
  - The hold counter increments each cycle the synchronized key stays low and saturates at `DASH_MIN`.
  - On release, the press is a dot if the counter is below `DASH_MIN`, otherwise a dash.
  - Append: `value` ← (`value` << plen) | pattern, and `length` ← `length` + plen, where plen is 2 for a dot and 4 for a dash. Then return to RECORD.
  - If `length` + plen > `WIDTH`, the symbol is dropped, `overflow` is set to 1 and the state returns to RECORD.
  - `done_input` and `next_input` are ignored in PRESS.
- DONE:
  - `valid` is 1. `user_input` and `done_input` are ignored.
  - A `next_input` press clears `value`, `length`, `overflow` and `valid`, and the state returns to RECORD.
- `resetn` low at any time, including mid-press, forces the reset state immediately. A key still held when reset releases does not produce a symbol, because no falling edge is seen.

## Timing
- Synchronizer latency is 2 cycles.
- `value` and `length` update on the clock edge after the synchronized release is seen, i.e. 3 cycles after the raw key rises.
- `valid` rises 3 cycles after the raw `done_input` falls. It clears 3 cycles after the raw `next_input` falls.
- All outputs are registered; there is no combinational path from the keys to the outputs.
- Hold duration is measured in synchronized cycles. With `DASH_MIN`=2, a press lasting 1 cycle is a dot and a press lasting 2 or more cycles is a dash.

## Configuration
- `PLAYER1_UNDO_EN` defined:
  - Keep a dash-flag stack of depth `WIDTH`/2, pushed on every appended symbol.
  - A `next_input` press in RECORD with `length`>0 pops the stack. It then shifts `value` right by 2 (dot) or 4 (dash), subtracts that from `length`, and clears `overflow`.
  - A `next_input` press in RECORD with `length`==0 is ignored.
- `PLAYER1_UNDO_EN` undefined: there is no stack, and `next_input` in RECORD is ignored.
- DONE-state behaviour is identical in both builds.

## Test plan
- Dot then dash: press for 1 cycle, release, then press for 3 cycles, release. Required: `value`=6'b101110 and `length`=6, with `valid`=0.
- Finish: after the dot-then-dash sequence, press `done_input`. Required: `valid`=1 after 3 cycles. Further `user_input` presses leave `value` at 6'b101110. A `next_input` press then returns all outputs to 0.
- Overflow: enter 5 dashes (20 bits), then 1 dot. Required: `length`=20, `value`=20'hEEEEE, `overflow`=1.
- Empty done: press `done_input` with `length`=0. Required: the state stays RECORD and `valid`=0.
- Reset mid-press: assert `resetn` low while `user_input` is held, then release `resetn` with the key still held, then release the key. Required: all outputs 0 and no symbol appended.
- Undo (`PLAYER1_UNDO_EN` defined): enter dot, dash, then press `next_input`. Required: `value`=2'b10 and `length`=2. Without the macro, the same stimulus leaves `value`=6'b101110.

Source files
------------

// File: rtl/player1.sv
// ============================================================================
// Module  : player1
// Brief   : Player-1 Morse-style code recorder (dot = 10, dash = 1110) that
//           holds the packed code with a valid flag for the player2 stage.
//           Optional undo stack enabled by defining PLAYER1_UNDO_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module player1 #(
    parameter int WIDTH    = 20,
    parameter int DASH_MIN = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             user_input,
    input  logic             next_input,
    input  logic             done_input,
    output logic [WIDTH-1:0] value,
    output logic [4:0]       length,
    output logic             valid,
    output logic             overflow,
    output logic [17:0]      q
);

    localparam int         CNT_W    = (DASH_MIN < 2) ? 1 : $clog2(DASH_MIN + 1);
    localparam logic [5:0] c_WIDTH6 = 6'(WIDTH);

    localparam logic [1:0] S_RECORD = 2'd0;
    localparam logic [1:0] S_PRESS  = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Key index: 0 = user, 1 = next, 2 = done
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [2:0] prev_q;
    logic [2:0] w_fall;
    logic [2:0] w_rise;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] value_q,    value_d;
    logic [4:0]       length_q,   length_d;
    logic             valid_q,    valid_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             w_dash;
    logic [4:0]       w_plen;
    logic [5:0]       w_sum;
    logic             w_fits;
    logic [WIDTH-1:0] w_pat;

    // Synchronizer flops reset to the "pressed" level so a key still held
    // when reset releases never presents a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= {done_input, next_input, user_input};
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign w_fall = prev_q & ~sync_q;
    assign w_rise = ~prev_q & sync_q;

    assign w_dash = (cnt_q >= CNT_W'(DASH_MIN));
    assign w_plen = w_dash ? 5'd4 : 5'd2;
    assign w_sum  = {1'b0, length_q} + {1'b0, w_plen};
    assign w_fits = (w_sum <= c_WIDTH6);
    assign w_pat  = w_dash ? WIDTH'(4'b1110) : WIDTH'(2'b10);

`ifdef PLAYER1_UNDO_EN
    localparam int DEPTH = WIDTH / 2;

    // Bit 0 is the most recently appended symbol (1 = dash).
    logic [DEPTH-1:0] stack_q, stack_d;
    logic [4:0]       w_pop_len;

    assign w_pop_len = stack_q[0] ? 5'd4 : 5'd2;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stack_q <= '0;
        end else begin
            stack_q <= stack_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        length_d   = length_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
`ifdef PLAYER1_UNDO_EN
        stack_d    = stack_q;
`endif
        case (state_q)
            S_RECORD: begin
                if (w_fall[0]) begin
                    state_d = S_PRESS;
                    cnt_d   = CNT_W'(1);
                end else if (w_fall[2] && (length_q != 5'd0)) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
`ifdef PLAYER1_UNDO_EN
                end else if (w_fall[1] && (length_q != 5'd0)) begin
                    value_d    = value_q >> w_pop_len;
                    length_d   = length_q - w_pop_len;
                    overflow_d = 1'b0;
                    stack_d    = {1'b0, stack_q[DEPTH-1:1]};
`endif
                end
            end
            S_PRESS: begin
                if (w_rise[0]) begin
                    state_d = S_RECORD;
                    if (w_fits) begin
                        value_d  = (value_q << w_plen) | w_pat;
                        length_d = w_sum[4:0];
`ifdef PLAYER1_UNDO_EN
                        stack_d  = {stack_q[DEPTH-2:0], w_dash};
`endif
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (!sync_q[0] && !w_dash) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (w_fall[1]) begin
                    state_d    = S_RECORD;
                    value_d    = '0;
                    length_d   = 5'd0;
                    valid_d    = 1'b0;
                    overflow_d = 1'b0;
`ifdef PLAYER1_UNDO_EN
                    stack_d    = '0;
`endif
                end
            end
            default: begin
                state_d = S_RECORD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_RECORD;
            value_q    <= '0;
            length_q   <= 5'd0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            length_q   <= length_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign value    = value_q;
    assign length   = length_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

    generate
        if (WIDTH >= 18) begin : g_q_slice
            assign q = value_q[17:0];
        end else begin : g_q_pad
            assign q = {{(18 - WIDTH){1'b0}}, value_q};
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_player1.sv
// ============================================================================
// Module  : tb_player1
// Brief   : Directed self-checking bench for player1 (default WIDTH=20,
//           DASH_MIN=2); undo expectations follow PLAYER1_UNDO_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_player1;

    logic        clock;
    logic        resetn;
    logic        user_input;
    logic        next_input;
    logic        done_input;
    logic [19:0] value;
    logic [4:0]  length;
    logic        valid;
    logic        overflow;
    logic [17:0] q;

    int checks = 0;
    int passes = 0;

    player1 #(.WIDTH(20), .DASH_MIN(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .user_input (user_input),
        .next_input (next_input),
        .done_input (done_input),
        .value      (value),
        .length     (length),
        .valid      (valid),
        .overflow   (overflow),
        .q          (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        resetn     = 1'b0;
        user_input = 1'b1;
        next_input = 1'b1;
        done_input = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    // Hold key k (0 user, 1 next, 2 done) low for n cycles; returns at release.
    task automatic press_key(input int k, input int n);
        @(negedge clock);
        case (k)
            0: user_input = 1'b0;
            1: next_input = 1'b0;
            default: done_input = 1'b0;
        endcase
        repeat (n) @(negedge clock);
        user_input = 1'b1;
        next_input = 1'b1;
        done_input = 1'b1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetn     = 1'b0;
        user_input = 1'b1;
        next_input = 1'b1;
        done_input = 1'b1;
        @(negedge clock);
        checks++; if (value !== 20'h0) $display("FAIL reset_value got %h want 00000", value); else passes++;
        checks++; if (length !== 5'd0) $display("FAIL reset_length got %0d want 0", length); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passes++;
        checks++; if (q !== 18'h0) $display("FAIL reset_q got %h want 00000", q); else passes++;
        resetn = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_dot_dash();
        do_reset();
        press_key(0, 1);
        repeat (2) @(negedge clock);
        checks++; if (length !== 5'd0) $display("FAIL dot_latency_early got %0d want 0", length); else passes++;
        @(negedge clock);
        checks++; if (length !== 5'd2) $display("FAIL dot_latency_3 got %0d want 2", length); else passes++;
        checks++; if (value !== 20'h2) $display("FAIL dot_value got %h want 00002", value); else passes++;
        settle();
        press_key(0, 3);
        settle();
        checks++; if (value !== 20'h2E) $display("FAIL dotdash_value got %h want 0002e", value); else passes++;
        checks++; if (length !== 5'd6) $display("FAIL dotdash_length got %0d want 6", length); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL dotdash_valid got %b want 0", valid); else passes++;
        checks++; if (q !== 18'h2E) $display("FAIL dotdash_q got %h want 0002e", q); else passes++;
    endtask

    task automatic test_finish();
        test_dot_dash();
        press_key(2, 1);
        @(negedge clock);
        checks++; if (valid !== 1'b0) $display("FAIL valid_early got %b want 0", valid); else passes++;
        @(negedge clock);
        checks++; if (valid !== 1'b1) $display("FAIL valid_rise got %b want 1", valid); else passes++;
        settle();
        press_key(0, 3);
        settle();
        press_key(2, 1);
        settle();
        checks++; if (value !== 20'h2E) $display("FAIL done_hold_value got %h want 0002e", value); else passes++;
        checks++; if (length !== 5'd6) $display("FAIL done_hold_length got %0d want 6", length); else passes++;
        checks++; if (valid !== 1'b1) $display("FAIL done_hold_valid got %b want 1", valid); else passes++;
        press_key(1, 1);
        @(negedge clock);
        checks++; if (valid !== 1'b1) $display("FAIL valid_clear_early got %b want 1", valid); else passes++;
        @(negedge clock);
        checks++; if (valid !== 1'b0) $display("FAIL valid_clear got %b want 0", valid); else passes++;
        checks++; if (value !== 20'h0) $display("FAIL clear_value got %h want 00000", value); else passes++;
        checks++; if (length !== 5'd0) $display("FAIL clear_length got %0d want 0", length); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL clear_overflow got %b want 0", overflow); else passes++;
        settle();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press_key(0, 2);
            settle();
        end
        checks++; if (value !== 20'hEEEEE) $display("FAIL full_value got %h want eeeee", value); else passes++;
        checks++; if (length !== 5'd20) $display("FAIL full_length got %0d want 20", length); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL full_overflow got %b want 0", overflow); else passes++;
        press_key(0, 1);
        settle();
        checks++; if (value !== 20'hEEEEE) $display("FAIL ovf_value got %h want eeeee", value); else passes++;
        checks++; if (length !== 5'd20) $display("FAIL ovf_length got %0d want 20", length); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passes++;
        checks++; if (q !== 18'h2EEEE) $display("FAIL ovf_q got %h want 2eeee", q); else passes++;
        press_key(1, 1);
        settle();
`ifdef PLAYER1_UNDO_EN
        checks++; if (value !== 20'h0EEEE) $display("FAIL ovf_undo_value got %h want 0eeee", value); else passes++;
        checks++; if (length !== 5'd16) $display("FAIL ovf_undo_length got %0d want 16", length); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_undo_flag got %b want 0", overflow); else passes++;
`else
        checks++; if (value !== 20'hEEEEE) $display("FAIL ovf_next_value got %h want eeeee", value); else passes++;
        checks++; if (length !== 5'd20) $display("FAIL ovf_next_length got %0d want 20", length); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_next_flag got %b want 1", overflow); else passes++;
`endif
    endtask

    task automatic test_empty_done();
        do_reset();
        press_key(2, 1);
        settle();
        checks++; if (valid !== 1'b0) $display("FAIL empty_done_valid got %b want 0", valid); else passes++;
        checks++; if (length !== 5'd0) $display("FAIL empty_done_length got %0d want 0", length); else passes++;
        press_key(0, 1);
        settle();
        checks++; if (length !== 5'd2) $display("FAIL empty_done_record got %0d want 2", length); else passes++;
        checks++; if (value !== 20'h2) $display("FAIL empty_done_value got %h want 00002", value); else passes++;
    endtask

    task automatic test_reset_midpress();
        do_reset();
        press_key(0, 1);
        settle();
        @(negedge clock);
        user_input = 1'b0;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        checks++; if (length !== 5'd0) $display("FAIL midpress_rst_length got %0d want 0", length); else passes++;
        checks++; if (value !== 20'h0) $display("FAIL midpress_rst_value got %h want 00000", value); else passes++;
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        user_input = 1'b1;
        settle();
        checks++; if (length !== 5'd0) $display("FAIL midpress_length got %0d want 0", length); else passes++;
        checks++; if (value !== 20'h0) $display("FAIL midpress_value got %h want 00000", value); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL midpress_valid got %b want 0", valid); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL midpress_overflow got %b want 0", overflow); else passes++;
        press_key(0, 4);
        settle();
        checks++; if (value !== 20'hE) $display("FAIL after_rst_dash got %h want 0000e", value); else passes++;
    endtask

    task automatic test_undo();
        do_reset();
        press_key(0, 1);
        settle();
        press_key(0, 2);
        settle();
        press_key(1, 1);
        settle();
`ifdef PLAYER1_UNDO_EN
        checks++; if (value !== 20'h2) $display("FAIL undo_value got %h want 00002", value); else passes++;
        checks++; if (length !== 5'd2) $display("FAIL undo_length got %0d want 2", length); else passes++;
        press_key(1, 1);
        settle();
        checks++; if (length !== 5'd0) $display("FAIL undo2_length got %0d want 0", length); else passes++;
        press_key(1, 1);
        settle();
        checks++; if (length !== 5'd0) $display("FAIL undo_empty_length got %0d want 0", length); else passes++;
`else
        checks++; if (value !== 20'h2E) $display("FAIL next_value got %h want 0002e", value); else passes++;
        checks++; if (length !== 5'd6) $display("FAIL next_length got %0d want 6", length); else passes++;
`endif
    endtask

    initial begin
        resetn     = 1'b1;
        user_input = 1'b1;
        next_input = 1'b1;
        done_input = 1'b1;
        test_reset();
        test_dot_dash();
        test_finish();
        test_overflow();
        test_empty_done();
        test_reset_midpress();
        test_undo();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
